// File: rtl/srl_fifo_ctrl_pkg.sv
// Shared types and helpers for the SRL FIFO controller.
package srl_fifo_ctrl_pkg;

  // Qualified operation seen by the controller in one cycle.
  typedef enum logic [1:0] {
    OpHold,
    OpPush,
    OpPop,
    OpBoth
  } fifo_op_e;

  // Registered status flags, all derived from the next occupancy.
  typedef struct packed {
    logic empty_n;
    logic full_n;
    logic almost_full;
  } fifo_flags_t;

  // Merge the qualified push/pop strobes into a single operation code.
  function automatic fifo_op_e decode_op(input logic push, input logic pop);
    fifo_op_e op;
    unique case ({push, pop})
      2'b10:   op = OpPush;
      2'b01:   op = OpPop;
      2'b11:   op = OpBoth;
      default: op = OpHold;
    endcase
    return op;
  endfunction

  // Occupancy after one cycle. Callers only issue OpPush when not full and
  // OpPop when not empty, so the result stays within 0..depth.
  function automatic int unsigned step_count(input int unsigned count, input fifo_op_e op);
    int unsigned next;
    unique case (op)
      OpPush:  next = count + 1;
      OpPop:   next = count - 1;
      default: next = count;
    endcase
    return next;
  endfunction

  // Flags for a given occupancy; thresh may be zero or negative, in which
  // case almost-full is permanently asserted.
  function automatic fifo_flags_t calc_flags(input int count, input int depth, input int thresh);
    fifo_flags_t f;
    f.empty_n     = (count != 0);
    f.full_n      = (count != depth);
    f.almost_full = (count >= thresh);
    return f;
  endfunction

endpackage

// File: rtl/srl_fifo_ctrl_store.sv
// Shift-register storage for the SRL FIFO: shift-in at index 0, random read.
module srl_fifo_ctrl_store #(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned ADDR_WIDTH = 1,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Shift every entry up by one and insert the new word at the bottom.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  // Read mux; addresses beyond DEPTH-1 are never produced by the controller.
  always_comb begin
    dout = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (addr == ADDR_WIDTH'(i)) begin
        dout = mem_q[i];
      end
    end
  end

endmodule

// File: rtl/srl_fifo_ctrl.sv
// Occupancy and handshake controller for a first-word-fall-through SRL FIFO.
module srl_fifo_ctrl
  import srl_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 1,
  parameter int unsigned ADDR_WIDTH  = 1,
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned AFULL_LEVEL = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  output logic                  if_almost_full,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   if_num_data
);

  localparam int unsigned CntW        = ADDR_WIDTH + 1;
  localparam int          AfullThresh = int'(DEPTH) - int'(AFULL_LEVEL);

  logic [CntW-1:0]       count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  fifo_flags_t           flags_q, flags_d;
  fifo_op_e              op;
  logic                  push, pop;

  // Handshakes qualify against the registered flags only: no full/empty bypass.
  assign push = if_write & if_write_ce & flags_q.full_n;
  assign pop  = if_read & if_read_ce & flags_q.empty_n;

  // Next occupancy, read pointer and flags.
  always_comb begin
    op      = decode_op(push, pop);
    count_d = CntW'(step_count(int'(count_q), op));
    addr_d  = '0;
    if (count_d != '0) begin
      addr_d = ADDR_WIDTH'(count_d - CntW'(1));
    end
    flags_d = calc_flags(int'(count_d), int'(DEPTH), AfullThresh);
  end

  // State update; reset wins over any push/pop in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q             <= '0;
      addr_q              <= '0;
      flags_q.empty_n     <= 1'b0;
      flags_q.full_n      <= 1'b1;
      flags_q.almost_full <= (AfullThresh <= 0);
    end else begin
      count_q <= count_d;
      addr_q  <= addr_d;
      flags_q <= flags_d;
    end
  end

  // Storage shifts only on an accepted write; a push-and-pop keeps addr_q, so
  // the shift itself brings the next-oldest word under the read pointer.
  srl_fifo_ctrl_store #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_store (
    .clk  (clk),
    .we   (push & ~reset),
    .addr (addr_q),
    .din  (if_din),
    .dout (if_dout)
  );

  assign if_full_n      = flags_q.full_n;
  assign if_almost_full = flags_q.almost_full;
  assign if_empty_n     = flags_q.empty_n;
  assign if_num_data    = count_q;

endmodule
